tcdm_mux: RTL and testbench

Arbitrating N-to-1 TCDM multiplexer that sits directly upstream of `tcdm_demux`: several TCDM masters share one TCDM master port feeding the demux/interconnect. The block arbitrates requests, forwards the winner's request, tracks the single outstanding transaction, and routes the response back to the issuing master.

---
 rtl/tcdm_mux.sv | 156 +++++++++++++++
 tb/tb_tcdm_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_mux.sv
// tcdm_mux: arbitrating N-to-1 TCDM multiplexer with a single outstanding
// transaction. Requests from several masters are arbitrated onto one
// downstream TCDM port, and the response is routed back to the issuer.
// Optional feature macro: TCDM_MUX_RR_EN
//   defined     -> round-robin arbitration starting at rr_q
//   not defined -> fixed priority, lowest requesting index wins
// A request that was presented but not granted stays locked until granted.
module tcdm_mux #(
  parameter int NR_INPUTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NR_INPUTS-1:0]                  in_req_i,
  input  logic [NR_INPUTS-1:0][ADDR_WIDTH-1:0]  in_add_i,
  input  logic [NR_INPUTS-1:0]                  in_wen_i,
  input  logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]  in_wdata_i,
  input  logic [NR_INPUTS-1:0][BE_WIDTH-1:0]    in_be_i,
  output logic [NR_INPUTS-1:0]                  in_gnt_o,
  output logic [NR_INPUTS-1:0]                  in_r_valid_o,
  output logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]  in_r_rdata_o,
  output logic [NR_INPUTS-1:0]                  in_r_opc_o,
  output logic                                  out_req_o,
  output logic [ADDR_WIDTH-1:0]                 out_add_o,
  output logic                                  out_wen_o,
  output logic [DATA_WIDTH-1:0]                 out_wdata_o,
  output logic [BE_WIDTH-1:0]                   out_be_o,
  input  logic                                  out_gnt_i,
  input  logic                                  out_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                 out_r_rdata_i,
  input  logic                                  out_r_opc_i
);

  localparam int IDX_W = (NR_INPUTS > 1) ? $clog2(NR_INPUTS) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] active_q, active_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] winner;
  logic             winner_valid;
  logic             issue_open;
  logic             resp_en;
`ifdef TCDM_MUX_RR_EN
  logic [IDX_W-1:0] rr_q, rr_d;
`endif

  // Winner selection: a locked (presented, ungranted) request always wins.
  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    if (lock_q) begin
      winner       = lock_idx_q;
      winner_valid = 1'b1;
    end else begin
      // Descending scan so the last hit is the highest-priority one.
      for (int i = NR_INPUTS - 1; i >= 0; i--) begin
`ifdef TCDM_MUX_RR_EN
        if (in_req_i[(int'(rr_q) + i) % NR_INPUTS]) begin
          winner       = IDX_W'((int'(rr_q) + i) % NR_INPUTS);
          winner_valid = 1'b1;
        end
`else
        if (in_req_i[i]) begin
          winner       = IDX_W'(i);
          winner_valid = 1'b1;
        end
`endif
      end
    end
  end

  // Issue window, request forwarding, grant return and next-state logic.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`ifdef TCDM_MUX_RR_EN
    rr_d        = rr_q;
`endif
    out_req_o   = 1'b0;
    out_add_o   = '0;
    out_wen_o   = 1'b1;
    out_wdata_o = '0;
    out_be_o    = '0;
    in_gnt_o    = '0;
    // Reset is asynchronous, so outputs are forced idle while it is held.
    issue_open  = !rst_i && ((state_q == IDLE) || out_r_valid_i);

    // Outstanding response completes; a new grant below may override this.
    if ((state_q == PENDING) && out_r_valid_i) begin
      state_d = IDLE;
    end

    if (issue_open && winner_valid) begin
      out_req_o   = 1'b1;
      out_add_o   = in_add_i[winner];
      out_wen_o   = in_wen_i[winner];
      out_wdata_o = in_wdata_i[winner];
      out_be_o    = in_be_i[winner];
      if (out_gnt_i) begin
        in_gnt_o[winner] = 1'b1;
        active_d         = winner;
        lock_d           = 1'b0;
        state_d          = PENDING;
`ifdef TCDM_MUX_RR_EN
        rr_d = (winner == IDX_W'(NR_INPUTS - 1)) ? '0 : winner + 1'b1;
`endif
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = winner;
        state_d    = IDLE;
      end
    end
  end

  assign resp_en = !rst_i && (state_q == PENDING);

  // Response lanes: only the issuing master sees the downstream response.
  generate
    for (genvar gi = 0; gi < NR_INPUTS; gi++) begin : g_resp
      logic lane_sel;
      assign lane_sel          = resp_en && (active_q == IDX_W'(gi));
      assign in_r_valid_o[gi]  = lane_sel && out_r_valid_i;
      assign in_r_opc_o[gi]    = lane_sel && out_r_opc_i;
      assign in_r_rdata_o[gi]  = lane_sel ? out_r_rdata_i : '0;
    end
  endgenerate

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      active_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`ifdef TCDM_MUX_RR_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`ifdef TCDM_MUX_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcdm_mux.sv
// Directed testbench for tcdm_mux (NR_INPUTS=2). Expected values are
// hand-computed; grant order depends on TCDM_MUX_RR_EN.
module tb_tcdm_mux;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef TCDM_MUX_RR_EN
  localparam logic [1:0]  EXP_G2   = 2'b10;
  localparam logic [31:0] EXP_ADD2 = 32'h0000_2000;
  localparam logic [1:0]  EXP_RV3  = 2'b10;
`else
  localparam logic [1:0]  EXP_G2   = 2'b01;
  localparam logic [31:0] EXP_ADD2 = 32'h0000_1000;
  localparam logic [1:0]  EXP_RV3  = 2'b01;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [N-1:0]          in_req_i;
  logic [N-1:0][AW-1:0]  in_add_i;
  logic [N-1:0]          in_wen_i;
  logic [N-1:0][DW-1:0]  in_wdata_i;
  logic [N-1:0][BW-1:0]  in_be_i;
  logic [N-1:0]          in_gnt_o;
  logic [N-1:0]          in_r_valid_o;
  logic [N-1:0][DW-1:0]  in_r_rdata_o;
  logic [N-1:0]          in_r_opc_o;
  logic                  out_req_o;
  logic [AW-1:0]         out_add_o;
  logic                  out_wen_o;
  logic [DW-1:0]         out_wdata_o;
  logic [BW-1:0]         out_be_o;
  logic                  out_gnt_i;
  logic                  out_r_valid_i;
  logic [DW-1:0]         out_r_rdata_i;
  logic                  out_r_opc_i;

  int vectors     = 0;
  int miscompares = 0;

  tcdm_mux #(
    .NR_INPUTS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BE_WIDTH  (BW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_req_i     (in_req_i),
    .in_add_i     (in_add_i),
    .in_wen_i     (in_wen_i),
    .in_wdata_i   (in_wdata_i),
    .in_be_i      (in_be_i),
    .in_gnt_o     (in_gnt_o),
    .in_r_valid_o (in_r_valid_o),
    .in_r_rdata_o (in_r_rdata_o),
    .in_r_opc_o   (in_r_opc_o),
    .out_req_o    (out_req_o),
    .out_add_o    (out_add_o),
    .out_wen_o    (out_wen_o),
    .out_wdata_o  (out_wdata_o),
    .out_be_o     (out_be_o),
    .out_gnt_i    (out_gnt_i),
    .out_r_valid_i(out_r_valid_i),
    .out_r_rdata_i(out_r_rdata_i),
    .out_r_opc_i  (out_r_opc_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    in_req_i      = '0;
    in_add_i      = '0;
    in_wen_i      = '1;
    in_wdata_i    = '0;
    in_be_i       = '0;
    out_gnt_i     = 1'b0;
    out_r_valid_i = 1'b0;
    out_r_rdata_i = '0;
    out_r_opc_i   = 1'b0;
  endtask

  initial begin
    // Reset held with activity on every input: everything must stay idle.
    rst_i = 1'b1;
    idle_inputs();
    in_req_i      = 2'b11;
    in_add_i[0]   = 32'h0000_1000;
    out_gnt_i     = 1'b1;
    out_r_valid_i = 1'b1;
    #2;
    check("rst_gnt",     in_gnt_o,     2'b00);
    check("rst_req",     out_req_o,    1'b0);
    check("rst_wen",     out_wen_o,    1'b1);
    check("rst_add",     out_add_o,    32'h0);
    check("rst_rvalid",  in_r_valid_o, 2'b00);
    cyc();
    cyc();
    rst_i = 1'b0;
    idle_inputs();
    cyc();

    // Both masters request continuously, grant always, response next cycle.
    in_req_i    = 2'b11;
    in_add_i[0] = 32'h0000_1000;
    in_add_i[1] = 32'h0000_2000;
    out_gnt_i   = 1'b1;
    #2;
    check("arb1_gnt", in_gnt_o,  2'b01);
    check("arb1_add", out_add_o, 32'h0000_1000);
    cyc();
    out_r_valid_i = 1'b1;
    #2;
    check("arb2_gnt",    in_gnt_o,     EXP_G2);
    check("arb2_add",    out_add_o,    EXP_ADD2);
    check("arb2_rvalid", in_r_valid_o, 2'b01);
    cyc();
    #2;
    check("arb3_gnt",    in_gnt_o,     2'b01);
    check("arb3_rvalid", in_r_valid_o, EXP_RV3);
    cyc();
    in_req_i = 2'b00;
    #2;
    check("arb4_rvalid", in_r_valid_o, 2'b01);
    check("arb4_req",    out_req_o,    1'b0);
    cyc();
    idle_inputs();
    cyc();

    // Lock: M1 presented without grant keeps the port while M0 joins.
    in_req_i    = 2'b10;
    in_add_i[1] = 32'h1C00_0040;
    #2;
    check("lock1_req", out_req_o, 1'b1);
    check("lock1_add", out_add_o, 32'h1C00_0040);
    check("lock1_gnt", in_gnt_o,  2'b00);
    cyc();
    in_req_i    = 2'b11;
    in_add_i[0] = 32'h0000_1000;
    #2;
    check("lock2_add", out_add_o, 32'h1C00_0040);
    cyc();
    #2;
    check("lock3_add", out_add_o, 32'h1C00_0040);
    cyc();
    out_gnt_i = 1'b1;
    #2;
    check("lock4_gnt", in_gnt_o,  2'b10);
    check("lock4_add", out_add_o, 32'h1C00_0040);
    cyc();
    idle_inputs();
    out_r_valid_i = 1'b1;
    out_r_rdata_i = 32'h1234_5678;
    #2;
    check("lock_rvalid", in_r_valid_o,    2'b10);
    check("lock_rdata1", in_r_rdata_o[1], 32'h1234_5678);
    check("lock_rdata0", in_r_rdata_o[0], 32'h0);
    cyc();
    idle_inputs();
    cyc();

    // Long latency response to M0, with M1 knocking while PENDING.
    in_req_i    = 2'b01;
    in_add_i[0] = 32'h0000_3000;
    out_gnt_i   = 1'b1;
    #2;
    check("lat_gnt0", in_gnt_o, 2'b01);
    cyc();
    in_req_i    = 2'b10;
    in_add_i[0] = '0;
    in_add_i[1] = 32'h0000_2000;
    in_wen_i    = 2'b01;
    in_wdata_i[1] = 32'h55AA_55AA;
    in_be_i[1]  = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      #2;
      check($sformatf("lat_wait%0d_req", c), out_req_o, 1'b0);
      check($sformatf("lat_wait%0d_gnt", c), {in_gnt_o, in_r_valid_o}, 4'b0000);
      cyc();
    end
    // Response for M0 and back-to-back write issue for M1 in one cycle.
    out_r_valid_i = 1'b1;
    out_r_rdata_i = 32'hDEAD_BEEF;
    #2;
    check("b2b_rvalid", in_r_valid_o,    2'b01);
    check("b2b_rdata0", in_r_rdata_o[0], 32'hDEAD_BEEF);
    check("b2b_rdata1", in_r_rdata_o[1], 32'h0);
    check("b2b_gnt",    in_gnt_o,        2'b10);
    check("b2b_wen",    out_wen_o,       1'b0);
    check("b2b_wdata",  out_wdata_o,     32'h55AA_55AA);
    check("b2b_be",     out_be_o,        4'h3);
    cyc();
    idle_inputs();
    out_r_valid_i = 1'b1;
    out_r_opc_i   = 1'b1;
    out_r_rdata_i = 32'hCAFE_F00D;
    #2;
    check("opc_rvalid", in_r_valid_o,    2'b10);
    check("opc_flags",  in_r_opc_o,      2'b10);
    check("opc_rdata1", in_r_rdata_o[1], 32'hCAFE_F00D);
    cyc();
    idle_inputs();
    cyc();

    // Reset while PENDING: outputs drop immediately, late response is lost.
    in_req_i    = 2'b01;
    in_add_i[0] = 32'h0000_4000;
    out_gnt_i   = 1'b1;
    #2;
    check("rstp_gnt", in_gnt_o, 2'b01);
    cyc();
    idle_inputs();
    #2;
    rst_i         = 1'b1;
    in_req_i      = 2'b10;
    in_add_i[1]   = 32'h0000_5000;
    out_gnt_i     = 1'b1;
    out_r_valid_i = 1'b1;
    out_r_rdata_i = 32'hBAD0_BAD0;
    #1;
    check("rstp_rvalid", in_r_valid_o,    2'b00);
    check("rstp_rdata0", in_r_rdata_o[0], 32'h0);
    check("rstp_gnt2",   in_gnt_o,        2'b00);
    check("rstp_req",    out_req_o,       1'b0);
    check("rstp_add",    out_add_o,       32'h0);
    cyc();
    rst_i = 1'b0;
    idle_inputs();
    out_r_valid_i = 1'b1;
    out_r_rdata_i = 32'hBAD0_BAD0;
    #2;
    check("late_rvalid", in_r_valid_o, 2'b00);
    cyc();
    idle_inputs();
    in_req_i    = 2'b10;
    in_add_i[1] = 32'h0000_6000;
    out_gnt_i   = 1'b1;
    #2;
    check("post_rst_gnt", in_gnt_o,  2'b10);
    check("post_rst_add", out_add_o, 32'h0000_6000);
    cyc();
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
